// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - Default values for the data width, word-address width and memory depth.
//   - FSM state type used by load_store_unit.
package lsu_pkg;

    localparam int unsigned LSU_DATA_W_DEF = 16;
    localparam int unsigned LSU_ADDR_W_DEF = 16;
    localparam int unsigned LSU_DEPTH_DEF  = 8;

    // Width of the external memory address and data buses.
    localparam int unsigned LSU_MEM_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between a valid/ready
// request pipeline and an external, combinationally-read data memory.
//
// Flow: IDLE --accept--> ACCESS (one-cycle write strobe or read enable)
//       --> RESP (resp_valid held until resp_ready) --> IDLE.
// Minimum issue interval is three cycles.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_we             1 = store, 0 = load
//   req_addr           word address (ADDR_W bits)
//   req_wdata          store data (DATA_W bits)
//   resp_valid/ready   response handshake
//   resp_rdata         load data, 0 for stores and rejected accesses
//   resp_err           access rejected (address check build only)
//   mem_access_addr    16-bit memory address, held between accesses
//   mem_write_data     16-bit store data, held between accesses
//   mem_write_en       one-cycle write strobe
//   mem_read           one-cycle read enable
//   mem_read_data      combinational read data from memory
//   busy               FSM not idle
//
// Build option: define LSU_ADDR_CHECK_EN to reject requests whose address is
// >= DEPTH. Rejected requests skip the memory access and respond with
// resp_err=1. Without it resp_err is constant 0 and the memory wraps on its
// low address bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = LSU_DATA_W_DEF,
    parameter int unsigned ADDR_W = LSU_ADDR_W_DEF,
    parameter int unsigned DEPTH  = LSU_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,

    output logic [LSU_MEM_W-1:0] mem_access_addr,
    output logic [LSU_MEM_W-1:0] mem_write_data,
    output logic                 mem_write_en,
    output logic                 mem_read,
    input  logic [LSU_MEM_W-1:0] mem_read_data,

    output logic                 busy
);

`ifdef LSU_ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif

    // Resizing goes through a vector at least as wide as both ends, so the
    // same slice performs zero-extension or truncation as the widths demand.
    localparam int unsigned AddrWide = (ADDR_W > LSU_MEM_W) ? ADDR_W : LSU_MEM_W;
    localparam int unsigned DataWide = (DATA_W > LSU_MEM_W) ? DATA_W : LSU_MEM_W;
    // Compare width large enough for any 32-bit DEPTH and any ADDR_W.
    localparam int unsigned CmpW     = ADDR_W + 32;

    lsu_state_e state;
    logic       we_q;

    logic [AddrWide-1:0]  addr_wide;
    logic [LSU_MEM_W-1:0] addr_mem;
    logic [DataWide-1:0]  wdata_wide;
    logic [LSU_MEM_W-1:0] wdata_mem;
    logic [DataWide-1:0]  rdata_wide;
    logic [DATA_W-1:0]    rdata_word;
    logic [CmpW-1:0]      addr_cmp;
    logic [CmpW-1:0]      depth_cmp;
    logic                 addr_oob;

    assign addr_wide  = AddrWide'(req_addr);
    assign addr_mem   = addr_wide[LSU_MEM_W-1:0];
    assign wdata_wide = DataWide'(req_wdata);
    assign wdata_mem  = wdata_wide[LSU_MEM_W-1:0];
    assign rdata_wide = DataWide'(mem_read_data);
    assign rdata_word = rdata_wide[DATA_W-1:0];

    assign addr_cmp  = CmpW'(req_addr);
    assign depth_cmp = CmpW'(DEPTH);
    // Constant 0 in the default build, so the reject path folds away.
    assign addr_oob  = AddrCheck && (addr_cmp >= depth_cmp);

    // Handshake status decodes straight from the state register.
    assign req_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    // Async reset clears the strobes immediately, so an access interrupted by
    // reset never commits a write at a following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            we_q            <= 1'b0;
            mem_access_addr <= '0;
            mem_write_data  <= '0;
            mem_write_en    <= 1'b0;
            mem_read        <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_err        <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        if (addr_oob) begin
                            // Rejected: no memory traffic, bus values untouched.
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else begin
                            state           <= StAccess;
                            we_q            <= req_we;
                            mem_access_addr <= addr_mem;
                            mem_write_data  <= wdata_mem;
                            mem_write_en    <= req_we;
                            mem_read        <= ~req_we;
                        end
                    end
                end

                StAccess: begin
                    state        <= StResp;
                    mem_write_en <= 1'b0;
                    mem_read     <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= we_q ? '0 : rdata_word;
                    resp_err     <= 1'b0;
                end

                StResp: begin
                    if (resp_ready) begin
                        state      <= StIdle;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end

                default: begin
                    state        <= StIdle;
                    mem_write_en <= 1'b0;
                    mem_read     <= 1'b0;
                    resp_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: external memory model, a transaction-level
// reference model checked every cycle, and directed scenarios with literal
// expectations.
module tb_load_store_unit;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [15:0]       mem_access_addr;
    logic [15:0]       mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [15:0]       mem_read_data;
    logic              busy;

    load_store_unit #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_access_addr(mem_access_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // External memory: wraps on low address bits, writes only outside reset.
    logic [15:0] mem [DEPTH] = '{default: 16'h0};
    assign mem_read_data = mem[mem_access_addr[2:0]];
    always @(posedge clk) begin
        if (!rst && mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef LSU_ADDR_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    // Reference model: at most one transaction in flight. Accepted at edge
    // m_acc; the memory strobe is visible in the cycle after that edge and the
    // response from the next cycle on (rejected requests respond at once).
    logic        m_have = 1'b0;
    logic        m_we = 1'b0;
    logic        m_oob = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    int          m_acc = 0;
    logic [15:0] ref_mem [DEPTH] = '{default: 16'h0};
    logic [15:0] last_addr = '0;
    logic [15:0] last_wdata = '0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          accept_log[$];

    always @(negedge clk) begin
        logic        e_busy, e_wr, e_rd, e_rv;
        logic [15:0] e_rdata;
        if (rst) begin
            chk("reset_ctrl", 32'({req_ready, resp_valid, resp_err, busy, mem_write_en, mem_read}),
                32'h20);
            chk("reset_data", {resp_rdata, mem_access_addr}, 32'h0);
            chk("reset_wdata", 32'(mem_write_data), 32'h0);
            m_have     = 1'b0;
            last_addr  = '0;
            last_wdata = '0;
        end else begin
            if (mem_read) rd_pulses++;
            if (mem_write_en) wr_pulses++;
            e_busy  = m_have && (cyc >= m_acc);
            e_wr    = m_have && (cyc == m_acc) && !m_oob && m_we;
            e_rd    = m_have && (cyc == m_acc) && !m_oob && !m_we;
            e_rv    = m_have && (m_oob ? (cyc >= m_acc) : (cyc >= m_acc + 1));
            e_rdata = (m_we || m_oob) ? 16'h0 : ref_mem[m_addr % DEPTH];
            if (e_wr || e_rd) begin
                last_addr  = m_addr;
                last_wdata = m_wdata;
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("req_ready", 32'(req_ready), 32'(!e_busy));
            chk("mem_write_en", 32'(mem_write_en), 32'(e_wr));
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("mem_access_addr", 32'(mem_access_addr), 32'(last_addr));
            chk("mem_write_data", 32'(mem_write_data), 32'(last_wdata));
            if (e_rv) begin
                chk("resp_rdata", 32'(resp_rdata), 32'(e_rdata));
                chk("resp_err", 32'(resp_err), 32'(m_oob));
            end
            if (e_wr) ref_mem[m_addr % DEPTH] = m_wdata;
            if (e_rv && resp_ready) m_have = 1'b0;
            if (req_valid && !e_busy) begin
                m_have  = 1'b1;
                m_acc   = cyc + 1;
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_oob   = Chk && (32'(req_addr) >= 32'(DEPTH));
                accept_log.push_back(cyc + 1);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL req_accept_timeout: req_ready stayed 0 at %0t", $time);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [15:0] data, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid stayed 0 at %0t", $time);
        end
        data = resp_rdata;
        err  = resp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        e;
        int          w0, r0, a0, n;

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Presets for later scenarios.
        do_req(1'b1, 16'd1, 16'h1111); wait_resp(d, e);
        do_req(1'b1, 16'd2, 16'h0022); wait_resp(d, e);
        do_req(1'b1, 16'd5, 16'h1234); wait_resp(d, e);
        chk("store_resp_zero", 32'(d), 32'h0);

        // Store then load.
        w0 = wr_pulses;
        do_req(1'b1, 16'd3, 16'hA5A5); wait_resp(d, e);
        chk("store_strobe_count", 32'(wr_pulses - w0), 32'd1);
        chk("mem3_written", 32'(mem[3]), 32'hA5A5);
        do_req(1'b0, 16'd3, 16'h0); wait_resp(d, e);
        chk("load3_data", 32'(d), 32'hA5A5);
        chk("load3_err", 32'(e), 32'h0);

        // Response back-pressure with a competing request.
        resp_ready = 1'b0;
        do_req(1'b0, 16'd5, 16'h0);
        a0 = accept_log.size();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'd6;
        req_wdata = 16'hDEAD;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'h1);
            chk("bp_rdata", 32'(resp_rdata), 32'h1234);
            chk("bp_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ignored", 32'(accept_log.size() - a0), 32'h0);
        chk("bp_mem6_untouched", 32'(mem[6]), 32'h0);

        // Back-to-back issue.
        accept_log.delete();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'd3;
        req_wdata = 16'h0;
        repeat (13) @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_accepts", 32'(accept_log.size()), 32'd5);
        for (int i = 1; i < accept_log.size(); i++) begin
            chk("b2b_spacing", 32'(accept_log[i] - accept_log[i-1]), 32'd3);
        end

        // Reset during the access cycle of a store.
        do_req(1'b1, 16'd2, 16'hBEEF);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", 32'({req_ready, resp_valid, busy, mem_write_en, mem_read}), 32'h10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem2_kept", 32'(mem[2]), 32'h0022);
        chk("rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        do_req(1'b0, 16'd2, 16'h0); wait_resp(d, e);
        chk("load2_after_rst", 32'(d), 32'h0022);

        // Out-of-range address.
        r0 = rd_pulses;
        do_req(1'b0, 16'h0009, 16'h0); wait_resp(d, e);
`ifdef LSU_ADDR_CHECK_EN
        chk("oob_err", 32'(e), 32'h1);
        chk("oob_rdata", 32'(d), 32'h0);
        chk("oob_no_read", 32'(rd_pulses - r0), 32'h0);
`else
        chk("wrap_rdata", 32'(d), 32'h1111);
        chk("wrap_err", 32'(e), 32'h0);
        chk("wrap_one_read", 32'(rd_pulses - r0), 32'h1);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
